// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the loader throttles the byte source.
interface imem_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    // byte source / memory observer side
    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );

    // loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Shifts stream bytes into a big-endian 32-bit word and flags the 4th byte.
// Latency: word valid on the cycle after the 4th shift; word_ready is combinational with it.
// Backpressure: none; shifts only when shift_en is asserted by the owner.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] idx;

    // the 4th byte of a word is the one arriving while idx is at its last value
    assign word_ready = shift_en && (idx == 2'd3);

    // shift register and byte index; clr realigns the index at the start of a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= 32'h0;
            idx  <= 2'd0;
        end else if (clr) begin
            idx  <= 2'd0;
        end else if (shift_en) begin
            word <= {word[23:0], byte_in};
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream (COUNT hi/lo, then big-endian words) -> one-cycle imem writes; holds CPU in reset until done.
// Latency: one write cycle after every 4th accepted data byte; minimum 5 cycles per word.
// Backpressure: in_ready low outside LEN_HI/LEN_LO/DATA(/CHK); optional trailing XOR byte with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.slave       bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] words_written
);

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [31:0]        STEP    = 32'(WORD_BYTES);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_full;
    logic [31:0]        waddr_q;
    logic [31:0]        word;
    logic               word_ready;
    logic               xfer;
    logic               start_ok;
    logic               shift_en;
    logic               last_word;

    assign xfer       = bus.in_valid && bus.in_ready;
    assign start_ok   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign shift_en   = xfer && (state_q == DATA);
    assign count_full = {count_q[COUNT_W-1:8], bus.in_data};
    assign last_word  = (words_written + 16'd1) == count_q;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .shift_en   (shift_en),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_ready (word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // running XOR over data bytes of the current load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else if (start_ok) begin
            csum_q <= 8'h00;
        end else if (shift_en) begin
            csum_q <= csum_q ^ bus.in_data;
        end
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN_HI;
            LEN_HI:          if (xfer) state_d = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (count_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if (count_full > DEPTH_C) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA:            if (word_ready) state_d = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (xfer) state_d = (bus.in_data == csum_q) ? DONE : ERR;
`endif
            default:         state_d = IDLE;
        endcase
    end

    // count latch, write address and word counter; the address stops on the last word so it stays in range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            waddr_q       <= BASE_ADDR;
            words_written <= '0;
        end else begin
            if (start_ok) begin
                waddr_q       <= BASE_ADDR;
                words_written <= '0;
            end
            if (xfer && state_q == LEN_HI) count_q[COUNT_W-1:8] <= bus.in_data;
            if (xfer && state_q == LEN_LO) count_q[7:0]         <= bus.in_data;
            if (state_q == WRITE) begin
                words_written <= words_written + 16'd1;
                if (!last_word) waddr_q <= waddr_q + STEP;
            end
        end
    end

    // outputs decoded from the registered state
    always_comb begin
        bus.in_ready = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA, CHK: bus.in_ready = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
        bus.we    = (state_q == WRITE);
        bus.waddr = waddr_q;
        bus.wdata = word;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: byte driver waits on in_ready with a bounded loop.
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               cpu_hold;
    logic               done;
    logic               error;
    logic [COUNT_W-1:0] words_written;

    int   vectors = 0;
    int   miscompares = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] img[$];

    imem_loader_if bus();

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_w(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // scoreboard monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.we) begin
            check("in_ready_during_write", 32'(bus.in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", bus.waddr, bus.wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", bus.waddr, mon_e.addr);
                check("wdata", bus.wdata, mon_e.data);
            end
        end
    end

    // called at a negedge; returns at the negedge after the byte transferred
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: byte %h not accepted after %0d cycles", b, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_img(input int gap);
        foreach (img[i]) begin
            send_byte(img[i]);
            repeat (gap) @(negedge clk);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (img[i]) if (i >= 2) x ^= img[i];
            send_byte(x);
        end
`endif
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end;
        int n;
        n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            vectors++;
            miscompares++;
            $display("FAIL end_timeout: neither done nor error after %0d cycles", n);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h, input logic [15:0] ww);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({tag, "_words_written"}, 32'(words_written), 32'(ww));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_waddr"}, bus.waddr, 32'h0);
        check({tag, "_wdata"}, bus.wdata, 32'h0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_written"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // two-word image, back-to-back bytes
        img = '{8'h00, 8'h02, 8'h20, 8'h05, 8'h00, 8'h0A, 8'h8C, 8'hA6, 8'h00, 8'h04};
        expect_w(32'h0, 32'h2005000A);
        expect_w(32'h4, 32'h8CA60004);
        pulse_start();
        send_img(0);
        wait_end();
        check_status("two_word", 1'b1, 1'b0, 1'b0, 16'd2);

        // same image, in_valid toggling; restart from DONE raises cpu_hold next cycle
        expect_w(32'h0, 32'h2005000A);
        expect_w(32'h4, 32'h8CA60004);
        pulse_start();
        check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        check("restart_done_clr", 32'(done), 32'd0);
        send_img(1);
        wait_end();
        check_status("toggle", 1'b1, 1'b0, 1'b0, 16'd2);

        // COUNT 257 exceeds DEPTH
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        wait_end();
        check_status("too_long", 1'b0, 1'b1, 1'b1, 16'd0);

        // recovery from ERR with a one-word image
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        expect_w(32'h0, 32'h12345678);
        pulse_start();
        check("err_restart_error_clr", 32'(error), 32'd0);
        send_img(0);
        wait_end();
        check_status("recover", 1'b1, 1'b0, 1'b0, 16'd1);

        // empty image
        img = '{8'h00, 8'h00};
        pulse_start();
        send_img(0);
        wait_end();
        check_status("empty", 1'b1, 1'b0, 1'b0, 16'd0);

        // reset during a 3-word load, after 6 data bytes
        img = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        expect_w(32'h0, 32'hAABBCCDD);
        pulse_start();
        foreach (img[i]) send_byte(img[i]);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midload_reset");
        check("midload_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        img = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        expect_w(32'h0, 32'h01020304);
        expect_w(32'h4, 32'h05060708);
        expect_w(32'h8, 32'h090A0B0C);
        pulse_start();
        send_img(0);
        wait_end();
        check_status("after_reset", 1'b1, 1'b0, 1'b0, 16'd3);

        // start pulse in the middle of DATA is ignored
        expect_w(32'h0, 32'hDEADBEEF);
        expect_w(32'h4, 32'hCAFEF00D);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        check("midstart_in_ready", 32'(bus.in_ready), 32'd1);
        check("midstart_cpu_hold", 32'(cpu_hold), 32'd1);
        img = '{8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        foreach (img[i]) send_byte(img[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
`endif
        wait_end();
        check_status("midstart", 1'b1, 1'b0, 1'b0, 16'd2);

        // full-depth image: COUNT == DEPTH is accepted, last address is the top word
        img = '{8'h01, 8'h00};
        for (int w = 0; w < 256; w++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(4 * w);
            b1 = 8'(4 * w + 1);
            b2 = 8'(4 * w + 2);
            b3 = 8'(4 * w + 3);
            img.push_back(b0);
            img.push_back(b1);
            img.push_back(b2);
            img.push_back(b3);
            expect_w(32'(4 * w), {b0, b1, b2, b3});
        end
        pulse_start();
        send_img(0);
        wait_end();
        check_status("full_depth", 1'b1, 1'b0, 1'b0, 16'd256);
        check("waddr_in_range", 32'(bus.waddr <= 32'h3FC), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // correct trailing checksum
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        expect_w(32'h0, 32'h12345678);
        pulse_start();
        foreach (img[i]) send_byte(img[i]);
        send_byte(8'h08);
        wait_end();
        check_status("csum_good", 1'b1, 1'b0, 1'b0, 16'd1);

        // wrong trailing checksum
        expect_w(32'h0, 32'h12345678);
        pulse_start();
        foreach (img[i]) send_byte(img[i]);
        send_byte(8'h09);
        wait_end();
        check_status("csum_bad", 1'b0, 1'b1, 1'b1, 16'd1);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one-cycle word writes at word-aligned byte addresses.
- Holds the CPU in reset (`cpu_hold`) until the image is fully written.
- Sits between the host/UART byte source and the instruction memory's write port.

Parameters:
- DEPTH, 256: instruction memory capacity in words; the maximum accepted word count.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte source has data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory write strobe, one cycle per word.
- waddr  out  32  byte address of the write; bits [1:0] are always 0.
- wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keeps the CPU in reset while 1.
- done  out  1  load completed successfully; level output.
- error  out  1  load aborted; level output.
- words_written  out  16  count of words written in the current load.

Behaviour:
- Reset values: in_ready=0, we=0, waddr=BASE_ADDR, wdata=0, cpu_hold=1, done=0, error=0, words_written=0, state=IDLE.
- Reset asserted mid-load: all outputs return to reset values immediately. Memory contents already written are left as-is and are unspecified to the bench.
- A byte transfers only when in_valid && in_ready on a rising edge. in_ready is a registered function of state; it does not depend combinationally on in_valid.
- Stream format:
  - Byte 0: COUNT[15:8]. Byte 1: COUNT[7:0].
  - Then COUNT*4 data bytes, most significant byte of each word first.
- States:
  - IDLE: in_ready=0, cpu_hold=1. On start: clear done/error/words_written, set waddr=BASE_ADDR, go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer: latch COUNT[15:8], go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer, using the completed COUNT:
    - COUNT==0: go to DONE.
    - COUNT>DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: in_ready=1.
    - Each transfer: wdata <= {wdata[23:0], in_data}; a 2-bit byte index increments.
    - 4th byte: go to WRITE.
  - WRITE: in_ready=0, we=1 for exactly this one cycle, with waddr/wdata stable.
    - Next cycle: waddr += 4, words_written += 1.
    - If words_written+1==COUNT: go to DONE (or CHK when the feature is on). Otherwise: go to DATA.
    - Per-word cost: 4 transfer cycles + 1 write cycle; minimum 5 cycles/word.
  - DONE: done=1, cpu_hold=0, in_ready=0. start restarts the load; cpu_hold rises to 1 on the cycle after start.
  - ERR: error=1, cpu_hold=1, in_ready=0. Only start or reset leaves this state.
- start received in LEN_HI/LEN_LO/DATA/WRITE is ignored.
- in_valid stalls of any length inside any state are legal; no timeout.
- waddr never exceeds BASE_ADDR+4*(DEPTH-1).

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN. When defined, the loader keeps a running 8-bit XOR of all data bytes, cleared on start.
- With macro:
  - After the last WRITE, go to CHK (in_ready=1) and accept one trailing byte.
  - If the byte equals the running XOR, go to DONE. Otherwise go to ERR.
  - COUNT==0 also goes through CHK, with expected value 8'h00.
- Without macro: no CHK state, no trailing byte, no XOR logic.

Decomposition:
- Shared package `imem_loader_pkg`:
  - State enum: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
  - Constants: WORD_BYTES=4, COUNT_W=16.
- Sub-module `byte_word_packer`: shift register plus 2-bit byte counter, with a word_ready output.

Test Plan:
- Load 00 02 | 20 05 00 0A | 8C A6 00 04 -> two we pulses: (0x0, 0x2005000A) then (0x4, 0x8CA60004); done=1, cpu_hold=0, words_written=2.
- Same image with in_valid toggling every other cycle -> identical writes; in_ready is 0 during each WRITE cycle.
- COUNT=0x0101 (257 > DEPTH) -> no we; error=1, cpu_hold=1. A following start plus a valid 1-word image -> done=1.
- rst_n pulsed low after 6 data bytes of a 3-word load -> outputs at reset values immediately; a subsequent full load writes from waddr=0.
- start asserted in the middle of DATA -> ignored; the load completes normally.
- With IMEM_LOADER_CHECKSUM_EN: image 00 01 | 12 34 56 78 | 08 -> done=1. Trailing byte 09 -> error=1, cpu_hold=1.
